// File: rtl/demux_1x2_2bits_fifo.sv
// Splits one word stream onto two FIFO lanes, each with a valid/pop consumer handshake.
// The target lane alternates on every accept, or follows an external selector.
module demux_1x2_2bits_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clok,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             sel_ext,
  input  logic             selector,
  output logic [WIDTH-1:0] data_out0,
  output logic             valid_out0,
  input  logic             pop0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out1,
  input  logic             pop1,
  output logic [CW-1:0]    count0,
  output logic [CW-1:0]    count1,
  output logic             err_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic                  toggle;
  logic                  tgt;
  logic                  accept;
  logic                  err_q;
  logic [1:0]            push;
  logic [1:0]            pop_eff;
  logic [1:0][CW-1:0]    cnt;
  logic [1:0][WIDTH-1:0] head;

  always_comb begin
    tgt       = sel_ext ? selector : toggle;
    ready_out = (cnt[tgt] != FULL);
    accept    = valid_in & ready_out;
    push      = {accept & tgt, accept & ~tgt};
    pop_eff   = {pop1 & (cnt[1] != '0), pop0 & (cnt[0] != '0)};
  end

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    lane_cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clok or negedge reset_L) begin
      if (!reset_L) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        lane_cnt <= '0;
      end else begin
        if (push[l])    wr_ptr <= wr_ptr + PW'(1);
        if (pop_eff[l]) rd_ptr <= rd_ptr + PW'(1);
        case ({push[l], pop_eff[l]})
          2'b10:   lane_cnt <= lane_cnt + CW'(1);
          2'b01:   lane_cnt <= lane_cnt - CW'(1);
          default: lane_cnt <= lane_cnt;
        endcase
      end
    end

    // Storage needs no reset: the head is masked to zero whenever the lane is empty.
    always_ff @(posedge clok) begin
      if (push[l]) mem[wr_ptr] <= data_in;
    end

    assign cnt[l]  = lane_cnt;
    assign head[l] = (lane_cnt != '0) ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clok or negedge reset_L) begin
    if (!reset_L) begin
      toggle <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept && !sel_ext) toggle <= ~toggle;
      if ((pop0 && cnt[0] == '0) || (pop1 && cnt[1] == '0)) err_q <= 1'b1;
    end
  end

  assign data_out0     = head[0];
  assign data_out1     = head[1];
  assign valid_out0    = (cnt[0] != '0);
  assign valid_out1    = (cnt[1] != '0);
  assign count0        = cnt[0];
  assign count1        = cnt[1];
  assign err_underflow = err_q;

endmodule

// File: tb/tb_demux_1x2_2bits_fifo.sv
// Scoreboard bench for demux_1x2_2bits_fifo: per-lane expected queues filled on accept,
// drained and compared on pop; status checked at the falling edge.
module tb_demux_1x2_2bits_fifo;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clok = 1'b0;
  logic             reset_L;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             sel_ext;
  logic             selector;
  logic [WIDTH-1:0] data_out0;
  logic             valid_out0;
  logic             pop0;
  logic [WIDTH-1:0] data_out1;
  logic             valid_out1;
  logic             pop1;
  logic [CW-1:0]    count0;
  logic [CW-1:0]    count1;
  logic             err_underflow;

  demux_1x2_2bits_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clok(clok), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .sel_ext(sel_ext), .selector(selector),
    .data_out0(data_out0), .valid_out0(valid_out0), .pop0(pop0),
    .data_out1(data_out1), .valid_out1(valid_out1), .pop1(pop1),
    .count0(count0), .count1(count1), .err_underflow(err_underflow)
  );

  always #5 clok = ~clok;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic             m_tog;
  logic             m_err;

  logic [11:0] obs;
  assign obs = {count0, count1, valid_out0, valid_out1, data_out0, data_out1};

  function automatic logic [11:0] exp_status();
    logic [1:0] h0, h1;
    h0 = (q0.size() != 0) ? q0[0] : 2'b00;
    h1 = (q1.size() != 0) ? q1[0] : 2'b00;
    return {3'(q0.size()), 3'(q1.size()), q0.size() != 0, q1.size() != 0, h0, h1};
  endfunction

  function automatic logic exp_ready();
    logic t;
    t = sel_ext ? selector : m_tog;
    return ((t ? q1.size() : q0.size()) != DEPTH);
  endfunction

  // One clock of the reference model, using the inputs currently driven.
  task automatic tick();
    logic t, acc;
    t   = sel_ext ? selector : m_tog;
    acc = valid_in && ((t ? q1.size() : q0.size()) != DEPTH);
    @(posedge clok);
    if (pop0) begin
      if (q0.size() != 0) void'(q0.pop_front()); else m_err = 1'b1;
    end
    if (pop1) begin
      if (q1.size() != 0) void'(q1.pop_front()); else m_err = 1'b1;
    end
    if (acc) begin
      if (t) q1.push_back(data_in); else q0.push_back(data_in);
      if (!sel_ext) m_tog = ~m_tog;
    end
    @(negedge clok);
  endtask

  task automatic model_clear();
    q0.delete(); q1.delete(); m_tog = 1'b0; m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; data_in = '0; pop0 = 1'b0; pop1 = 1'b0;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; sel_ext = 1'b0; selector = 1'b0;
    idle_inputs();
    model_clear();
    #12;
    n_tests++;
    if ({obs, ready_out, err_underflow} !== {12'h000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", {obs, ready_out, err_underflow}, {12'h000, 1'b1, 1'b0});
    end
    reset_L = 1'b1;
    @(negedge clok);
  endtask

  task automatic test_alternate();
    logic [1:0] words [4];
    words = '{2'b01, 2'b10, 2'b11, 2'b00};
    sel_ext = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; data_in = words[i];
      #1;
      n_tests++;
      if (ready_out !== exp_ready()) begin
        n_fail++; $display("FAIL alt_ready[%0d]: got %b expected %b", i, ready_out, exp_ready());
      end
      tick();
      n_tests++;
      if (obs !== exp_status()) begin
        n_fail++; $display("FAIL alt_status[%0d]: got %h expected %h", i, obs, exp_status());
      end
    end
    idle_inputs();
    n_tests++;
    if ({count0, count1} !== {3'd2, 3'd2}) begin
      n_fail++; $display("FAIL alt_counts: got %0d/%0d expected 2/2", count0, count1);
    end
    pop0 = 1'b1; pop1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({data_out0, data_out1} !== {q0[0], q1[0]}) begin
        n_fail++; $display("FAIL alt_pop[%0d]: got %h/%h expected %h/%h", i, data_out0, data_out1, q0[0], q1[0]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_full_stall();
    logic [1:0] words [5];
    words = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    sel_ext = 1'b1; selector = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; data_in = words[i];
      #1;
      n_tests++;
      if (ready_out !== exp_ready()) begin
        n_fail++; $display("FAIL full_ready[%0d]: got %b expected %b", i, ready_out, exp_ready());
      end
      if (i < 4) tick();
    end
    n_tests++;
    if ({count0, ready_out} !== {3'd4, 1'b0}) begin
      n_fail++; $display("FAIL full_stall: got count0=%0d ready=%b expected 4/0", count0, ready_out);
    end
    pop0 = 1'b1;
    #1;
    n_tests++;
    if (ready_out !== 1'b0) begin
      n_fail++; $display("FAIL full_no_passthru: got %b expected 0", ready_out);
    end
    n_tests++;
    if (data_out0 !== q0[0]) begin
      n_fail++; $display("FAIL full_pop_head: got %h expected %h", data_out0, q0[0]);
    end
    tick();
    pop0 = 1'b0;
    #1;
    n_tests++;
    if (ready_out !== 1'b1) begin
      n_fail++; $display("FAIL full_ready_after_pop: got %b expected 1", ready_out);
    end
    tick();
    valid_in = 1'b0;
    n_tests++;
    if (obs !== exp_status() || count0 !== 3'd4) begin
      n_fail++; $display("FAIL full_refill: got %h expected %h", obs, exp_status());
    end
    pop0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (data_out0 !== q0[0]) begin
        n_fail++; $display("FAIL full_drain[%0d]: got %h expected %h", i, data_out0, q0[0]);
      end
      tick();
    end
    idle_inputs();
    n_tests++;
    if (obs !== 12'h000) begin
      n_fail++; $display("FAIL full_empty: got %h expected 000", obs);
    end
  endtask

  task automatic test_wrap();
    sel_ext = 1'b1; selector = 1'b1;
    for (int i = 0; i < 11; i++) begin
      valid_in = (i < 10);
      data_in  = 2'($urandom_range(0, 3));
      pop1     = (i > 0);
      #1;
      if (pop1) begin
        n_tests++;
        if (data_out1 !== q1[0]) begin
          n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, data_out1, q1[0]);
        end
      end
      tick();
      if (i < 10) begin
        n_tests++;
        if (count1 !== 3'd1) begin
          n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected 1", i, count1);
        end
      end
    end
    idle_inputs();
    n_tests++;
    if ({obs, err_underflow} !== {12'h000, 1'b0}) begin
      n_fail++; $display("FAIL wrap_end: got %h expected %h", {obs, err_underflow}, {12'h000, 1'b0});
    end
  endtask

  task automatic test_underflow();
    pop1 = 1'b1;
    tick();
    pop1 = 1'b0;
    n_tests++;
    if ({count1, data_out1, err_underflow} !== {3'd0, 2'b00, 1'b1}) begin
      n_fail++; $display("FAIL underflow: got %0d/%h/%b expected 0/0/1", count1, data_out1, err_underflow);
    end
    tick(); tick();
    n_tests++;
    if (err_underflow !== m_err) begin
      n_fail++; $display("FAIL underflow_sticky: got %b expected %b", err_underflow, m_err);
    end
  endtask

  task automatic test_mode_switch();
    reset_L = 1'b0; #1;
    n_tests++;
    if (err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL err_cleared: got %b expected 0", err_underflow);
    end
    model_clear();
    reset_L = 1'b1;
    @(negedge clok);
    sel_ext = 1'b0; valid_in = 1'b1; data_in = 2'b11; tick();
    sel_ext = 1'b1; selector = 1'b0;
    data_in = 2'b10; tick();
    data_in = 2'b01; tick();
    sel_ext = 1'b0; data_in = 2'b00; tick();
    idle_inputs();
    n_tests++;
    if ({count0, count1} !== {3'd3, 3'd1}) begin
      n_fail++; $display("FAIL mode_counts: got %0d/%0d expected 3/1", count0, count1);
    end
    n_tests++;
    if (obs !== exp_status()) begin
      n_fail++; $display("FAIL mode_status: got %h expected %h", obs, exp_status());
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset_L = 1'b0;
    #1;
    n_tests++;
    if ({count0, valid_out0, data_out0, ready_out} !== {3'd0, 1'b0, 2'b00, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", {count0, valid_out0, data_out0, ready_out}, {3'd0, 1'b0, 2'b00, 1'b1});
    end
    model_clear();
    #1;
    reset_L = 1'b1;
    @(negedge clok);
    sel_ext = 1'b0; valid_in = 1'b1; data_in = 2'b10; tick();
    idle_inputs();
    n_tests++;
    if ({count0, count1, data_out0} !== {3'd1, 3'd0, 2'b10}) begin
      n_fail++; $display("FAIL post_reset_lane0: got %0d/%0d/%h expected 1/0/2", count0, count1, data_out0);
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_full_stall();
    test_wrap();
    test_underflow();
    test_mode_switch();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
